// File: rtl/ahbext_pkg.sv
// Shared state encoding, HTRANS codes and LFSR constants for the external-RAM AHB subordinate.
package ahbext_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ext_sram_array.sv
// ext_sram_array: DEPTH x AHBW register file with per-byte write enables.
// Latency: write commits at the clock edge; read is combinational from i_addr.
// Backpressure: none, every cycle can write.
module ext_sram_array #(
    parameter int DEPTH = 4096,
    parameter int AHBW  = 64,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [IDXW-1:0]     i_addr,
    input  logic [AHBW/8-1:0]   i_strb,
    input  logic [AHBW-1:0]     i_wdata,
    output logic [AHBW-1:0]     o_rdata
);

    logic [AHBW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < AHBW/8; b++) begin
                if (i_strb[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_ext_sram.sv
// ahb_ext_sram: AHB-Lite subordinate backing the HSELEXT region with an internal register-file RAM.
// Latency: data phase completes 1+WAIT_CYCLES cycles after the address phase; out-of-range is a 2-cycle ERROR.
// Backpressure: HREADYEXT low in wait states and ERR1. EXTRAM_RANDSTALL_EN adds 0..3 LFSR wait states.
module ahb_ext_sram
    import ahbext_pkg::*;
#(
    parameter int                 PA_BITS     = 34,
    parameter int                 AHBW        = 64,
    parameter logic [PA_BITS-1:0] BASE        = '0,
    parameter int                 DEPTH       = 4096,
    parameter int                 WAIT_CYCLES = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSELEXT,
    input  logic [PA_BITS-1:0]  HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic [AHBW-1:0]     HWDATA,
    input  logic [AHBW/8-1:0]   HWSTRB,
    input  logic                HREADY,
    output logic [AHBW-1:0]     HRDATAEXT,
    output logic                HREADYEXT,
    output logic                HRESPEXT
);

    localparam int LANEW = $clog2(AHBW/8);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [PA_BITS:0] REGION_W = (PA_BITS+1)'(DEPTH * (AHBW/8));

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_issue_state;
    logic [4:0]        r_wcnt;
    logic [4:0]        w_wait_total;
    logic              r_write;
    logic [IDXW-1:0]   r_idx;
    logic [AHBW-1:0]   r_rdata;
    logic [AHBW-1:0]   w_rd;
    logic [PA_BITS-1:0] w_off;
    logic              w_in_range;
    logic              w_can_issue;
    logic              w_accept;
    logic              w_we;
    logic              w_unused;

    // Transfer size and burst type carry no information here: strobes select lanes, bursts go beat by beat.
    assign w_unused    = ^{HSIZE, HBURST};

    assign w_off       = HADDR - BASE;
    assign w_in_range  = (HADDR >= BASE) && ({1'b0, w_off} < REGION_W);
    assign w_can_issue = (r_state == IDLE) || (r_state == DATA) || (r_state == ERR2);
    assign w_accept    = HSELEXT && HREADY && w_can_issue
                         && !((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_BUSY));

`ifdef EXTRAM_RANDSTALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept && w_in_range) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_wait_total = 5'(WAIT_CYCLES) + {3'b000, r_lfsr[1:0]};
`else
    assign w_wait_total = 5'(WAIT_CYCLES);
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_issue_state = IDLE;
        if (w_accept) begin
            if (!w_in_range) begin
                w_issue_state = ERR1;
            end else if (w_wait_total == 5'd0) begin
                w_issue_state = DATA;
            end else begin
                w_issue_state = WAIT;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DATA, ERR2: w_state_nxt = w_issue_state;
            WAIT:             if (r_wcnt == 5'd1) w_state_nxt = DATA;
            ERR1:             w_state_nxt = ERR2;
            default:          w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        HREADYEXT = 1'b1;
        HRESPEXT  = 1'b0;
        HRDATAEXT = r_rdata;
        w_we      = 1'b0;
        case (r_state)
            WAIT: HREADYEXT = 1'b0;
            DATA: begin
                if (r_write) w_we = 1'b1;
                else         HRDATAEXT = w_rd;
            end
            ERR1: begin
                HREADYEXT = 1'b0;
                HRESPEXT  = 1'b1;
                HRDATAEXT = '0;
            end
            ERR2: begin
                HRESPEXT  = 1'b1;
                HRDATAEXT = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wcnt  <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == WAIT) begin
                r_wcnt <= r_wcnt - 5'd1;
            end else if (w_state_nxt == WAIT) begin
                r_wcnt <= w_wait_total;
            end
            if (w_accept) begin
                r_write <= HWRITE;
                r_idx   <= w_off[LANEW +: IDXW];
            end
            // Keeps the last read word visible between read data phases.
            if ((r_state == DATA) && !r_write) begin
                r_rdata <= w_rd;
            end
        end
    end

    ext_sram_array #(
        .DEPTH (DEPTH),
        .AHBW  (AHBW)
    ) u_array (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_strb  (HWSTRB),
        .i_wdata (HWDATA),
        .o_rdata (w_rd)
    );

endmodule
